// File: rtl/eth_rx_fcs_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : eth_rx_fcs_check
// Purpose  : Ethernet receive FCS checker sitting directly behind gmii_rx in
//            the RX_CLK domain. Checks the reflected CRC-32 over every frame
//            (FCS included), strips the 4 FCS bytes through a 5-byte delay
//            line, tags the last payload byte and flags frames to discard
//            (CRC residue mismatch, runt, oversize, PHY error). No
//            backpressure: the stream runs at line rate.
//
// Ports    : CLK          RX clock, all logic on the rising edge
//            RST          asynchronous active-high reset
//            i_valid      byte strobe, contiguous for a whole frame
//            i_data[7:0]  frame byte, DA first, FCS last
//            i_err        PHY error qualifier for the current byte
//            o_valid      payload byte strobe
//            o_data[7:0]  payload byte
//            o_last       final payload byte of the frame
//            o_bad        with o_last: frame must be discarded
//            o_len[15:0]  with o_last: payload length (frame length - 4)
//            o_drop       1-cycle pulse, frame of <= 4 bytes, nothing emitted
//            o_good_cnt / o_bad_cnt / o_drop_cnt [31:0]
//                         frame statistics, present only when the macro
//                         ETH_RX_STATS_EN is defined
//
// Options  : ETH_RX_STATS_EN  adds the three wrapping 32-bit frame counters
//
// Revision : 1.0  initial release
// ============================================================================
module eth_rx_fcs_check #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_err,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_last,
  output logic        o_bad,
  output logic [15:0] o_len,
  output logic        o_drop
`ifdef ETH_RX_STATS_EN
  ,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_bad_cnt,
  output logic [31:0] o_drop_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [31:0] c_crc_init    = 32'hFFFF_FFFF;
  localparam logic [31:0] c_crc_poly    = 32'hEDB8_8320;
  // Register value left behind when the CRC runs over data plus a correct FCS.
  localparam logic [31:0] c_crc_residue = 32'hDEBB_20E3;
  localparam int          c_buf_depth   = 5;
  localparam logic [15:0] c_fill_last   = 16'(c_buf_depth - 1);
  localparam logic [15:0] c_fcs_len     = 16'd4;
  localparam logic [15:0] c_cnt_max     = 16'hFFFF;
  localparam logic [15:0] c_min_len     = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] c_max_len     = 16'(MAX_FRAME_LEN);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_DISCARD = 2'd0,   // swallow a frame already in flight
    ST_IDLE    = 2'd1,   // wait for the first byte of a frame
    ST_FILL    = 2'd2,   // priming the delay line, nothing emitted yet
    ST_RUN     = 2'd3    // delay line full, one byte in / one byte out
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic [31:0] r_crc;
  logic [15:0] r_count;
  logic        r_err;
  logic [7:0]  r_buf [0:c_buf_depth-1];   // [0] newest, [c_buf_depth-1] oldest

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic        w_accept;     // i_data is part of the current frame
  logic        w_first;      // byte 0 of a new frame
  logic        w_shift_out;  // emit oldest buffered byte, frame continues
  logic        w_end;        // first idle cycle after a running frame
  logic        w_drop;       // frame ended while the delay line was priming
  logic        w_bad;
  logic [15:0] w_len;
  logic [31:0] w_crc_base;
  logic [31:0] w_crc_upd;

  // One byte of the reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ d[b]) begin
        c = (c >> 1) ^ c_crc_poly;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Byte 0 always restarts from the seed, so whatever the register holds
  // from the previous frame never leaks into the next one.
  assign w_crc_base = (r_state == ST_IDLE) ? c_crc_init : r_crc;
  assign w_crc_upd  = crc32_byte(w_crc_base, i_data);

  // End-of-frame verdict, evaluated on the idle cycle after the last byte,
  // so r_crc and r_count already include the final FCS byte.
  assign w_bad = (r_crc != c_crc_residue) ||
                 (r_count < c_min_len)    ||
                 (r_count > c_max_len)    ||
                 r_err;
  assign w_len = r_count - c_fcs_len;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_DISCARD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_first     = 1'b0;
    w_shift_out = 1'b0;
    w_end       = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_DISCARD: begin
        if (!i_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (i_valid) begin
          w_accept    = 1'b1;
          w_first     = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (i_valid) begin
          w_accept = 1'b1;
          // r_count is the number of bytes already held; this one fills
          // the delay line.
          if (r_count == c_fill_last) begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_drop      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_valid) begin
          w_accept    = 1'b1;
          w_shift_out = 1'b1;
        end else begin
          w_end       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_DISCARD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // CRC, byte counter, sticky PHY error
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_crc   <= c_crc_init;
      r_count <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_crc <= w_crc_upd;
      end

      if (w_first) begin
        r_count <= 16'd1;
      end else if (w_accept && (r_count != c_cnt_max)) begin
        r_count <= r_count + 16'd1;
      end

      if (w_first) begin
        r_err <= i_err;
      end else if (w_accept) begin
        r_err <= r_err | i_err;
      end else if (r_state == ST_IDLE) begin
        r_err <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // 5-byte delay line. Once the frame ends, the four newest entries are the
  // FCS and are simply left behind; the next frame overwrites them.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < c_buf_depth; k++) begin
        r_buf[k] <= 8'h00;
      end
    end else if (w_accept) begin
      r_buf[0] <= i_data;
      for (int k = 1; k < c_buf_depth; k++) begin
        r_buf[k] <= r_buf[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs. Qualifier-only fields are forced to zero outside
  // their strobe so the FIFO write side never sees stale values.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_valid <= 1'b0;
      o_data  <= 8'h00;
      o_last  <= 1'b0;
      o_bad   <= 1'b0;
      o_len   <= 16'd0;
      o_drop  <= 1'b0;
    end else begin
      o_valid <= w_shift_out | w_end;
      o_data  <= (w_shift_out | w_end) ? r_buf[c_buf_depth-1] : 8'h00;
      o_last  <= w_end;
      o_bad   <= w_end & w_bad;
      o_len   <= w_end ? w_len : 16'd0;
      o_drop  <= w_drop;
    end
  end

`ifdef ETH_RX_STATS_EN
  // --------------------------------------------------------------------------
  // Frame statistics, updated on the same edge that raises o_last / o_drop.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_good_cnt <= 32'd0;
      o_bad_cnt  <= 32'd0;
      o_drop_cnt <= 32'd0;
    end else begin
      if (w_end && !w_bad) begin
        o_good_cnt <= o_good_cnt + 32'd1;
      end
      if (w_end && w_bad) begin
        o_bad_cnt <= o_bad_cnt + 32'd1;
      end
      if (w_drop) begin
        o_drop_cnt <= o_drop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_fcs_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_fcs_check
// Purpose  : Directed self-checking bench for eth_rx_fcs_check. Frames are
//            built with a correct (or deliberately corrupted) FCS, driven one
//            byte per clock, and the emitted payload is collected by a
//            monitor on the falling edge and compared against hand-known
//            lengths, verdicts and byte patterns.
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_rx_fcs_check;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_err = 1'b0;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_last;
  logic        o_bad;
  logic [15:0] o_len;
  logic        o_drop;
`ifdef ETH_RX_STATS_EN
  logic [31:0] o_good_cnt;
  logic [31:0] o_bad_cnt;
  logic [31:0] o_drop_cnt;
`endif

  eth_rx_fcs_check #(
    .MIN_FRAME_LEN (64),
    .MAX_FRAME_LEN (1518)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_err   (i_err),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_bad   (o_bad),
    .o_len   (o_len),
    .o_drop  (o_drop)
`ifdef ETH_RX_STATS_EN
    ,
    .o_good_cnt (o_good_cnt),
    .o_bad_cnt  (o_bad_cnt),
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  always #4 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Frame under construction
  logic [7:0] frame [0:2047];
  int         frame_len = 0;

  // Monitor state
  logic [7:0]  out_q [$];
  logic [15:0] len_q [$];
  logic        bad_q [$];
  int          last_cnt  = 0;
  int          drop_cnt  = 0;
  int          drv_idx   = -1;
  int          first_idx = -1;

  always @(negedge CLK) begin
    if (o_valid === 1'b1) begin
      if (first_idx < 0) first_idx = drv_idx;
      out_q.push_back(o_data);
      if (o_last === 1'b1) begin
        len_q.push_back(o_len);
        bad_q.push_back(o_bad);
      end
    end
    if (o_last === 1'b1) last_cnt++;
    if (o_drop === 1'b1) drop_cnt++;
  end

  task automatic mon_clear();
    out_q.delete();
    len_q.delete();
    bad_q.delete();
    last_cnt  = 0;
    drop_cnt  = 0;
    first_idx = -1;
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Payload byte i = i mod 256, followed by the FCS (complemented CRC, LSB
  // byte first); fcs_xor is applied to the first FCS byte.
  task automatic build_frame(input int plen, input logic [7:0] fcs_xor);
    logic [31:0] crc;
    logic [31:0] fcs;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      frame[i] = 8'(i);
      crc = crc_step(crc, frame[i]);
    end
    fcs = ~crc;
    for (int j = 0; j < 4; j++) frame[plen + j] = fcs[8*j +: 8];
    frame[plen] = frame[plen] ^ fcs_xor;
    frame_len = plen + 4;
  endtask

  task automatic send_frame(input int err_at);
    for (int i = 0; i < frame_len; i++) begin
      @(posedge CLK); #1;
      i_valid = 1'b1;
      i_data  = frame[i];
      i_err   = (i == err_at);
      drv_idx = i;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      i_valid = 1'b0;
      i_data  = 8'h00;
      i_err   = 1'b0;
      drv_idx = -1;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({o_valid, o_data, o_last, o_bad, o_len, o_drop} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {o_valid, o_data, o_last, o_bad, o_len, o_drop});
    end
    // Frame already in flight when reset releases must be swallowed whole.
    mon_clear();
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      i_valid = 1'b1;
      i_data  = 8'hA0 + 8'(i);
      if (i == 3) RST = 1'b0;
    end
    idle(4);
    n_cmp++;
    if (out_q.size() !== 0 || last_cnt !== 0 || drop_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_discard: got bytes=%0d last=%0d drop=%0d want 0/0/0", out_q.size(), last_cnt, drop_cnt);
    end
  endtask

  task automatic test_min_frame();
    int nb;
    mon_clear();
    build_frame(60, 8'h00);
    send_frame(-1);
    idle(4);
    n_cmp++;
    if (out_q.size() !== 60) begin
      n_err++; $display("FAIL min_count: got %0d want 60", out_q.size());
    end
    nb = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 8'(i)) nb++;
    n_cmp++;
    if (nb !== 0) begin
      n_err++; $display("FAIL min_data: got %0d wrong bytes want 0", nb);
    end
    n_cmp++;
    if (first_idx !== 6) begin
      n_err++; $display("FAIL min_latency: first o_valid while driving byte %0d want 6", first_idx);
    end
    n_cmp++;
    if (last_cnt !== 1 || len_q.size() !== 1 || bad_q.size() !== 1) begin
      n_err++; $display("FAIL min_last: got %0d last pulses want 1", last_cnt);
    end else begin
      n_cmp++;
      if (bad_q[0] !== 1'b0 || len_q[0] !== 16'd60) begin
        n_err++; $display("FAIL min_verdict: got bad=%0b len=%0d want bad=0 len=60", bad_q[0], len_q[0]);
      end
    end
  endtask

  task automatic test_bad_fcs();
    mon_clear();
    build_frame(60, 8'h01);
    send_frame(-1);
    idle(4);
    n_cmp++;
    if (out_q.size() !== 60 || last_cnt !== 1 || len_q.size() !== 1) begin
      n_err++; $display("FAIL badfcs_count: got bytes=%0d last=%0d want 60/1", out_q.size(), last_cnt);
    end else begin
      n_cmp++;
      if (bad_q[0] !== 1'b1 || len_q[0] !== 16'd60) begin
        n_err++; $display("FAIL badfcs_verdict: got bad=%0b len=%0d want bad=1 len=60", bad_q[0], len_q[0]);
      end
    end
  endtask

  task automatic test_short();
    mon_clear();
    frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33;
    frame_len = 3;
    send_frame(-1);
    idle(4);
    n_cmp++;
    if (drop_cnt !== 1 || out_q.size() !== 0 || last_cnt !== 0) begin
      n_err++; $display("FAIL short_drop: got drop=%0d bytes=%0d last=%0d want 1/0/0", drop_cnt, out_q.size(), last_cnt);
    end
  endtask

  task automatic test_runt();
    mon_clear();
    build_frame(16, 8'h00);
    send_frame(-1);
    idle(4);
    n_cmp++;
    if (out_q.size() !== 16 || last_cnt !== 1 || len_q.size() !== 1 || drop_cnt !== 0) begin
      n_err++; $display("FAIL runt_count: got bytes=%0d last=%0d drop=%0d want 16/1/0", out_q.size(), last_cnt, drop_cnt);
    end else begin
      n_cmp++;
      if (bad_q[0] !== 1'b1 || len_q[0] !== 16'd16) begin
        n_err++; $display("FAIL runt_verdict: got bad=%0b len=%0d want bad=1 len=16", bad_q[0], len_q[0]);
      end
    end
  endtask

  task automatic test_phy_err();
    mon_clear();
    build_frame(96, 8'h00);
    send_frame(50);
    idle(4);
    n_cmp++;
    if (out_q.size() !== 96 || last_cnt !== 1 || len_q.size() !== 1) begin
      n_err++; $display("FAIL phyerr_count: got bytes=%0d last=%0d want 96/1", out_q.size(), last_cnt);
    end else begin
      n_cmp++;
      if (bad_q[0] !== 1'b1 || len_q[0] !== 16'd96) begin
        n_err++; $display("FAIL phyerr_verdict: got bad=%0b len=%0d want bad=1 len=96", bad_q[0], len_q[0]);
      end
    end
  endtask

  task automatic test_max_len();
    int nb;
    // 1518 bytes total: largest legal frame
    mon_clear();
    build_frame(1514, 8'h00);
    send_frame(-1);
    idle(4);
    nb = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 8'(i)) nb++;
    n_cmp++;
    if (out_q.size() !== 1514 || nb !== 0) begin
      n_err++; $display("FAIL max_data: got bytes=%0d wrong=%0d want 1514/0", out_q.size(), nb);
    end
    n_cmp++;
    if (len_q.size() !== 1 || bad_q[0] !== 1'b0 || len_q[0] !== 16'd1514) begin
      n_err++; $display("FAIL max_verdict: got n=%0d bad=%0b len=%0d want 1/0/1514", len_q.size(), bad_q[0], len_q[0]);
    end
    // 1519 bytes total: one over
    mon_clear();
    build_frame(1515, 8'h00);
    send_frame(-1);
    idle(4);
    n_cmp++;
    if (len_q.size() !== 1 || bad_q[0] !== 1'b1 || len_q[0] !== 16'd1515) begin
      n_err++; $display("FAIL oversize_verdict: got n=%0d bad=%0b len=%0d want 1/1/1515", len_q.size(), bad_q[0], len_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    int nb;
    mon_clear();
    build_frame(60, 8'h00);
    send_frame(-1);
    idle(1);
    send_frame(-1);
    idle(4);
    nb = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 8'(i % 60)) nb++;
    n_cmp++;
    if (out_q.size() !== 120 || nb !== 0) begin
      n_err++; $display("FAIL b2b_data: got bytes=%0d wrong=%0d want 120/0", out_q.size(), nb);
    end
    n_cmp++;
    if (last_cnt !== 2 || len_q.size() !== 2) begin
      n_err++; $display("FAIL b2b_last: got %0d last pulses want 2", last_cnt);
    end else begin
      n_cmp++;
      if (bad_q[0] !== 1'b0 || bad_q[1] !== 1'b0 || len_q[0] !== 16'd60 || len_q[1] !== 16'd60) begin
        n_err++; $display("FAIL b2b_verdict: got bad=%0b/%0b len=%0d/%0d want 0/0 60/60", bad_q[0], bad_q[1], len_q[0], len_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    build_frame(1514, 8'h00);
    for (int i = 0; i < frame_len; i++) begin
      @(posedge CLK); #1;
      i_valid = 1'b1;
      i_data  = frame[i];
      i_err   = 1'b0;
      drv_idx = i;
      if (i == 30) begin
        RST = 1'b1;
        #1;
        n_cmp++;
        if ({o_valid, o_data, o_last, o_bad, o_len, o_drop} !== 28'd0) begin
          n_err++; $display("FAIL midrst_clear: got %h want 0", {o_valid, o_data, o_last, o_bad, o_len, o_drop});
        end
        mon_clear();
      end
      if (i == 33) RST = 1'b0;
    end
    idle(4);
    n_cmp++;
    if (out_q.size() !== 0 || last_cnt !== 0 || drop_cnt !== 0) begin
      n_err++; $display("FAIL midrst_tail: got bytes=%0d last=%0d drop=%0d want 0/0/0", out_q.size(), last_cnt, drop_cnt);
    end
    mon_clear();
    build_frame(60, 8'h00);
    send_frame(-1);
    idle(4);
    n_cmp++;
    if (out_q.size() !== 60 || len_q.size() !== 1) begin
      n_err++; $display("FAIL midrst_next_count: got bytes=%0d last=%0d want 60/1", out_q.size(), len_q.size());
    end else begin
      n_cmp++;
      if (bad_q[0] !== 1'b0 || len_q[0] !== 16'd60) begin
        n_err++; $display("FAIL midrst_next_verdict: got bad=%0b len=%0d want bad=0 len=60", bad_q[0], len_q[0]);
      end
    end
`ifdef ETH_RX_STATS_EN
    // Counters were cleared by the mid-frame reset; only one good frame since.
    n_cmp++;
    if (o_good_cnt !== 32'd1 || o_bad_cnt !== 32'd0 || o_drop_cnt !== 32'd0) begin
      n_err++; $display("FAIL stats: got good=%0d bad=%0d drop=%0d want 1/0/0", o_good_cnt, o_bad_cnt, o_drop_cnt);
    end
`endif
  endtask

  // --------------------------------------------------------------------------
  initial begin
    #2;
    test_reset();
    test_min_frame();
    test_bad_fcs();
    test_short();
    test_runt();
    test_phy_err();
    test_max_len();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_rx_fcs_check.md
Name: eth_rx_fcs_check

Overview:
- Receive-path stage directly downstream of gmii_rx, in the RX_CLK domain.
- Consumes the gmii_rx byte stream (valid/data) and checks the Ethernet FCS (CRC-32) over each frame.
- Strips the 4 FCS bytes, marks the last payload byte, and flags bad frames (CRC, length, PHY error).
- Output feeds the RX FIFO write side; there is no backpressure because the stream runs at line rate.

Parameters:
- MIN_FRAME_LEN, 64, minimum legal frame length in bytes including FCS.
- MAX_FRAME_LEN, 1518, maximum legal frame length in bytes including FCS.

Ports:
- CLK  input  1  RX clock, 125 MHz; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- i_valid  input  1  byte strobe from gmii_rx; high contiguously for the whole frame.
- i_data  input  8  frame byte, destination address first, FCS last.
- i_err  input  1  PHY error during the frame (RX_ERR qualified by gmii_rx).
- o_valid  output  1  payload byte strobe.
- o_data  output  8  payload byte.
- o_last  output  1  high with the final payload byte.
- o_bad  output  1  valid only with o_last; 1 means the frame is to be discarded.
- o_len  output  16  payload length (frame length minus 4), valid with o_last.
- o_drop  output  1  one-cycle pulse: frame of 4 bytes or fewer, nothing emitted.

Behaviour:
- Reset: all outputs 0, state DISCARD, CRC register 0xFFFFFFFF, byte count 0, buffer cleared.
- States:
  - DISCARD: wait for i_valid=0, then go to IDLE. Entered after reset so a frame in progress at reset release is never partially accepted.
  - IDLE: on i_valid=1, accept byte 0, set count=1 and CRC seeded from 0xFFFFFFFF, then go to FILL.
  - FILL: accept bytes while count<5. On the 5th byte go to RUN. If i_valid=0 in FILL, pulse o_drop for 1 cycle and go to IDLE; no o_valid is produced.
  - RUN: each accepted byte pushes into a 5-byte delay buffer. The oldest byte is registered out with o_valid=1, o_last=0.
- End of frame in RUN:
  - The first cycle with i_valid=0 ends the frame.
  - Next cycle: o_valid=1, o_last=1, o_data is the oldest buffered byte (the last payload byte), o_len=count-4, o_bad computed as below.
  - State returns to IDLE. The 4 remaining buffer bytes are the FCS and are discarded.
- Latency: payload byte k is output the cycle after frame byte k+5 is accepted. The last payload byte is output the cycle after the first i_valid=0 cycle.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, LSB-first per byte.
  - Init 0xFFFFFFFF, computed over all bytes including the FCS.
  - The frame is good only if the CRC register equals the residue 0xDEBB20E3 after the last byte.
- o_bad=1 if any of:
  - CRC residue mismatch;
  - count<MIN_FRAME_LEN;
  - count>MAX_FRAME_LEN;
  - i_err was seen high on any accepted byte of the frame (sticky, cleared in IDLE).
- Byte count: 16 bits, saturates at 0xFFFF. o_len is reported from the saturated value.
- A new frame may start in the cycle immediately after the end cycle; the minimum gap is 1 cycle with i_valid=0.
- o_valid never asserts two cycles after i_valid has been low for 2 or more cycles.
- Reset mid-frame: outputs clear asynchronously and the state goes to DISCARD. The frame tail is ignored until i_valid=0.

Optional Feature:
- Macro: ETH_RX_STATS_EN.
- Defined:
  - Adds outputs o_good_cnt[31:0], o_bad_cnt[31:0] and o_drop_cnt[31:0].
  - Each increments by 1 on the o_last cycle (good or bad respectively) or on the o_drop pulse.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Min frame: 60 payload bytes 0x00..0x3B plus correct FCS (64 total) → 60 o_valid pulses in order; last has o_last=1, o_bad=0, o_len=60. First o_valid occurs the cycle after input byte 5.
- Corrupted FCS: same frame with FCS byte 0 XOR 0x01 → 60 bytes out, o_last with o_bad=1, o_len=60.
- Short and runt frames:
  - 3-byte frame → o_drop pulses once, no o_valid.
  - 20-byte frame with correct FCS → 16 bytes out, o_bad=1 (runt), o_len=16.
- PHY error: 100-byte good-FCS frame with i_err=1 on byte 50 only → o_bad=1, o_len=96.
- Back-to-back frames: two 64-byte good frames separated by exactly 1 idle cycle → 120 payload bytes, two o_last pulses both o_bad=0, no merged data.
- Reset mid-frame: assert RST at byte 30 of a 1518-byte frame, release while i_valid=1 → no outputs until i_valid falls. The following good 64-byte frame → o_bad=0, o_len=60.
